// File: rtl/kvadd_example_pkg.sv
// kvadd_example_pkg: shared types for the kvadd AXI4 slave memory.
// Holds the write/read FSM state enums and the address-LSB helper.
package kvadd_example_pkg;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_DATA
    } rd_state_t;

    // Number of byte-offset bits below the word index for a data width.
    function automatic int addr_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/kvadd_example_bram_dp.sv
// kvadd_example_bram_dp: simple dual-port RAM, byte-enabled write port,
// registered read port (1-cycle latency, read-first on address collision).
// Ports:
//   clk          clock
//   rst          sync active-high reset, clears only the read register
//   we/waddr     write enable and word address
//   wdata/wbe    write data and per-byte enables
//   re/raddr     read enable and word address
//   rdata        registered read data, holds while re=0
module kvadd_example_bram_dp #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 1024,
    localparam int AW   = $clog2(DEPTH),
    localparam int NB   = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [NB-1:0]    wbe,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (wbe[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Non-blocking read of mem sees the pre-write contents: read-first.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/kvadd_example_axi_slave_mem.sv
// kvadd_example_axi_slave_mem: AXI4 (reduced subset) slave memory with
// independent INCR-only write and read burst engines over a dual-port RAM.
// Ports:
//   aclk, areset            clock, sync active-high reset
//   s_axi_aw*/w*/b*         write address, data and response channels
//   s_axi_ar*/r*            read address and data channels
//   wr_burst_count          write bursts completed at B handshake
//   rd_burst_count          read bursts completed at final R handshake
//   protocol_error          sticky wlast/awlen disagreement flag
module kvadd_example_axi_slave_mem
    import kvadd_example_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int C_MEM_DEPTH_WORDS  = 1024
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]                      s_axi_awlen,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wlast,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]                      s_axi_arlen,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic                            s_axi_rlast,
    output logic [31:0]                     wr_burst_count,
    output logic [31:0]                     rd_burst_count,
    output logic                            protocol_error
);

    localparam int LSB = addr_lsb(C_M_AXI_DATA_WIDTH);
    localparam int IW  = $clog2(C_MEM_DEPTH_WORDS);

    wr_state_t         w_state;
    logic [IW-1:0]     w_idx;
    logic [7:0]        w_len;
    logic [7:0]        w_cnt;
    logic              w_fire;
    logic              w_final;

    rd_state_t         r_state;
    logic [IW-1:0]     r_idx;
    logic [7:0]        r_len;
    logic [7:0]        r_cnt;

    logic              ram_we;
    logic              ram_re;

    // Byte offset and aliasing upper bits are intentionally dropped.
    logic              addr_unused;
    assign addr_unused = ^{s_axi_awaddr[C_M_AXI_ADDR_WIDTH-1:LSB+IW],
                           s_axi_awaddr[LSB-1:0],
                           s_axi_araddr[C_M_AXI_ADDR_WIDTH-1:LSB+IW],
                           s_axi_araddr[LSB-1:0]};

    assign w_fire  = s_axi_wready & s_axi_wvalid;
    assign w_final = (w_cnt == w_len);

    // Suppress the write on a reset cycle so an aborted beat never lands.
    assign ram_we = w_fire & ~areset;
    assign ram_re = (r_state == R_FETCH);

    kvadd_example_bram_dp #(
        .WIDTH (C_M_AXI_DATA_WIDTH),
        .DEPTH (C_MEM_DEPTH_WORDS)
    ) u_ram (
        .clk   (aclk),
        .rst   (areset),
        .we    (ram_we),
        .waddr (w_idx),
        .wdata (s_axi_wdata),
        .wbe   (s_axi_wstrb),
        .re    (ram_re),
        .raddr (r_idx),
        .rdata (s_axi_rdata)
    );

    // Write engine: one outstanding burst, one beat per cycle.
    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state        <= W_IDLE;
            s_axi_awready  <= 1'b1;
            s_axi_wready   <= 1'b0;
            s_axi_bvalid   <= 1'b0;
            w_idx          <= '0;
            w_len          <= '0;
            w_cnt          <= '0;
            wr_burst_count <= '0;
            protocol_error <= 1'b0;
        end else begin
            unique case (w_state)
                W_IDLE: begin
                    if (s_axi_awvalid && s_axi_awready) begin
                        w_idx         <= s_axi_awaddr[LSB +: IW];
                        w_len         <= s_axi_awlen;
                        w_cnt         <= '0;
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b1;
                        w_state       <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        // awlen governs length; wlast is only audited.
                        if (s_axi_wlast != w_final) begin
                            protocol_error <= 1'b1;
                        end
                        w_idx <= w_idx + 1'b1;
                        w_cnt <= w_cnt + 8'd1;
                        if (w_final) begin
                            s_axi_wready <= 1'b0;
                            s_axi_bvalid <= 1'b1;
                            w_state      <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        wr_burst_count <= wr_burst_count + 32'd1;
                        s_axi_bvalid   <= 1'b0;
                        s_axi_awready  <= 1'b1;
                        w_state        <= W_IDLE;
                    end
                end
                default: begin
                    s_axi_awready <= 1'b1;
                    s_axi_wready  <= 1'b0;
                    s_axi_bvalid  <= 1'b0;
                    w_state       <= W_IDLE;
                end
            endcase
        end
    end

    // Read engine: fetch then present, one beat per two cycles.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state        <= R_IDLE;
            s_axi_arready  <= 1'b1;
            s_axi_rvalid   <= 1'b0;
            s_axi_rlast    <= 1'b0;
            r_idx          <= '0;
            r_len          <= '0;
            r_cnt          <= '0;
            rd_burst_count <= '0;
        end else begin
            unique case (r_state)
                R_IDLE: begin
                    if (s_axi_arvalid && s_axi_arready) begin
                        r_idx         <= s_axi_araddr[LSB +: IW];
                        r_len         <= s_axi_arlen;
                        r_cnt         <= '0;
                        s_axi_arready <= 1'b0;
                        r_state       <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    s_axi_rvalid <= 1'b1;
                    s_axi_rlast  <= (r_cnt == r_len);
                    r_state      <= R_DATA;
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        s_axi_rvalid <= 1'b0;
                        s_axi_rlast  <= 1'b0;
                        if (s_axi_rlast) begin
                            rd_burst_count <= rd_burst_count + 32'd1;
                            s_axi_arready  <= 1'b1;
                            r_state        <= R_IDLE;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_cnt   <= r_cnt + 8'd1;
                            r_state <= R_FETCH;
                        end
                    end
                end
                default: begin
                    s_axi_arready <= 1'b1;
                    s_axi_rvalid  <= 1'b0;
                    s_axi_rlast   <= 1'b0;
                    r_state       <= R_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kvadd_example_axi_slave_mem.sv
// Bench for kvadd_example_axi_slave_mem: directed and random bursts
// checked against a word-array memory model and expected counters.
module tb_kvadd_example_axi_slave_mem;

    localparam int AW = 64;
    localparam int DW = 512;
    localparam int NB = DW / 8;
    localparam int DEPTH = 1024;

    logic          aclk;
    logic          areset;
    logic          awvalid, awready;
    logic [AW-1:0] awaddr;
    logic [7:0]    awlen;
    logic          wvalid, wready;
    logic [DW-1:0] wdata;
    logic [NB-1:0] wstrb;
    logic          wlast;
    logic          bvalid, bready;
    logic          arvalid, arready;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic          rvalid, rready;
    logic [DW-1:0] rdata;
    logic          rlast;
    logic [31:0]   wr_cnt, rd_cnt;
    logic          perr;

    kvadd_example_axi_slave_mem #(
        .C_M_AXI_ADDR_WIDTH (AW),
        .C_M_AXI_DATA_WIDTH (DW),
        .C_MEM_DEPTH_WORDS  (DEPTH)
    ) dut (
        .aclk           (aclk),
        .areset         (areset),
        .s_axi_awvalid  (awvalid),
        .s_axi_awready  (awready),
        .s_axi_awaddr   (awaddr),
        .s_axi_awlen    (awlen),
        .s_axi_wvalid   (wvalid),
        .s_axi_wready   (wready),
        .s_axi_wdata    (wdata),
        .s_axi_wstrb    (wstrb),
        .s_axi_wlast    (wlast),
        .s_axi_bvalid   (bvalid),
        .s_axi_bready   (bready),
        .s_axi_arvalid  (arvalid),
        .s_axi_arready  (arready),
        .s_axi_araddr   (araddr),
        .s_axi_arlen    (arlen),
        .s_axi_rvalid   (rvalid),
        .s_axi_rready   (rready),
        .s_axi_rdata    (rdata),
        .s_axi_rlast    (rlast),
        .wr_burst_count (wr_cnt),
        .rd_burst_count (rd_cnt),
        .protocol_error (perr)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int            n_tests;
    int            n_fail;
    int unsigned   exp_wr;
    int unsigned   exp_rd;
    logic [DW-1:0] model  [DEPTH];
    logic [DW-1:0] wbeats [256];
    logic [NB-1:0] wstrbs [256];

    task automatic check(input string tag,
                         input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic int word_of(input logic [AW-1:0] a);
        return int'((a / NB) % DEPTH);
    endfunction

    task automatic axi_write(input logic [AW-1:0] addr, input int len,
                             input int last_at, input int bdelay);
        int n;
        int base;
        int idx;
        base    = word_of(addr);
        awaddr  = addr;
        awlen   = len[7:0];
        awvalid = 1'b1;
        n = 0;
        while (!awready && n < 50) begin @(negedge aclk); n++; end
        check("aw_ready", awready, 1);
        @(negedge aclk);
        awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            wvalid = 1'b1;
            wdata  = wbeats[i];
            wstrb  = wstrbs[i];
            wlast  = (i == last_at);
            n = 0;
            while (!wready && n < 50) begin @(negedge aclk); n++; end
            check("w_ready", wready, 1);
            idx = (base + i) % DEPTH;
            for (int b = 0; b < NB; b++)
                if (wstrbs[i][b]) model[idx][b*8 +: 8] = wbeats[i][b*8 +: 8];
            @(negedge aclk);
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        n = 0;
        while (!bvalid && n < 50) begin @(negedge aclk); n++; end
        check("b_valid", bvalid, 1);
        for (int d = 0; d < bdelay; d++) begin
            @(negedge aclk);
            check("b_hold", bvalid, 1);
        end
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        exp_wr++;
        check("b_drop", bvalid, 0);
        check("wr_count", wr_cnt, exp_wr);
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input int len,
                            input int stall_beat, input int stall_n,
                            input int stop_after);
        int n;
        int base;
        logic [DW-1:0] exp;
        base    = word_of(addr);
        araddr  = addr;
        arlen   = len[7:0];
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin @(negedge aclk); n++; end
        check("ar_ready", arready, 1);
        @(negedge aclk);
        arvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if (i == stop_after) return;
            n = 0;
            while (!rvalid && n < 50) begin @(negedge aclk); n++; end
            check("r_valid", rvalid, 1);
            exp = model[(base + i) % DEPTH];
            check("r_data", rdata, exp);
            check("r_last", rlast, (i == len));
            if (i == stall_beat) begin
                for (int d = 0; d < stall_n; d++) begin
                    @(negedge aclk);
                    check("r_hold_v", rvalid, 1);
                    check("r_hold_d", rdata, exp);
                    check("r_hold_l", rlast, (i == len));
                end
            end
            rready = 1'b1;
            @(negedge aclk);
            rready = 1'b0;
            check("r_gap", rvalid, 0);
        end
        exp_rd++;
        check("rd_count", rd_cnt, exp_rd);
    endtask

    initial begin
        logic [AW-1:0] a;
        int            len;
        n_tests = 0;
        n_fail  = 0;
        exp_wr  = 0;
        exp_rd  = 0;
        areset  = 1'b1;
        awvalid = 1'b0; awaddr = '0; awlen = '0;
        wvalid  = 1'b0; wdata  = '0; wstrb = '0; wlast = 1'b0;
        bready  = 1'b0;
        arvalid = 1'b0; araddr = '0; arlen = '0;
        rready  = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        repeat (3) @(negedge aclk);
        check("rst_awready", awready, 1);
        check("rst_arready", arready, 1);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rlast", rlast, 0);
        check("rst_rdata", rdata, '0);
        check("rst_wrcnt", wr_cnt, 0);
        check("rst_rdcnt", rd_cnt, 0);
        check("rst_perr", perr, 0);
        areset = 1'b0;
        @(negedge aclk);

        // Write then read back four beats.
        wbeats[0] = {NB{8'h11}}; wbeats[1] = {NB{8'h22}};
        wbeats[2] = {NB{8'h33}}; wbeats[3] = {NB{8'h44}};
        for (int i = 0; i < 4; i++) wstrbs[i] = '1;
        axi_write(64'h0, 3, 3, 0);
        axi_read(64'h0, 3, -1, 0, -1);

        // Partial strobe on word 5.
        wbeats[0] = {NB{8'hFF}}; wstrbs[0] = '1;
        axi_write(64'h140, 0, 0, 0);
        wbeats[0] = '0; wstrbs[0] = 64'hF;
        axi_write(64'h140, 0, 0, 0);
        axi_read(64'h140, 0, -1, 0, -1);

        // Index wrap from word 1023 to word 0.
        wbeats[0] = rnd_word(); wbeats[1] = rnd_word();
        wstrbs[0] = '1; wstrbs[1] = '1;
        axi_write(64'hFFC0, 1, 1, 0);
        axi_read(64'hFFC0, 0, -1, 0, -1);
        axi_read(64'h0, 0, -1, 0, -1);
        axi_read(64'hFFC0, 1, -1, 0, -1);

        // Backpressure on R and B.
        for (int i = 0; i < 4; i++) begin
            wbeats[i] = rnd_word(); wstrbs[i] = '1;
        end
        axi_write(64'h200, 3, 3, 3);
        axi_read(64'h200, 3, 1, 5, -1);

        // wlast early on beat 2 of 4.
        check("perr_pre", perr, 0);
        for (int i = 0; i < 4; i++) begin
            wbeats[i] = rnd_word(); wstrbs[i] = '1;
        end
        axi_write(64'h400, 3, 1, 0);
        check("perr_set", perr, 1);
        axi_read(64'h400, 3, -1, 0, -1);
        check("perr_sticky", perr, 1);

        // Random bursts with aliasing, unaligned addresses and strobes.
        for (int r = 0; r < 6; r++) begin
            a   = {$urandom, $urandom};
            len = $urandom_range(0, 7);
            for (int i = 0; i <= len; i++) begin
                wbeats[i] = rnd_word(); wstrbs[i] = '1;
            end
            axi_write(a, len, len, $urandom_range(0, 2));
            for (int i = 0; i <= len; i++) begin
                wbeats[i] = rnd_word();
                wstrbs[i] = {$urandom, $urandom};
            end
            axi_write(a, len, len, 0);
            axi_read(a ^ 64'h3F, len, $urandom_range(0, len),
                     $urandom_range(0, 3), -1);
        end

        // Reset after two of four read beats.
        axi_read(64'h0, 3, -1, 0, 2);
        areset = 1'b1;
        @(negedge aclk);
        check("mid_rvalid", rvalid, 0);
        check("mid_arready", arready, 1);
        check("mid_awready", awready, 1);
        check("mid_wrcnt", wr_cnt, 0);
        check("mid_rdcnt", rd_cnt, 0);
        check("mid_perr", perr, 0);
        areset = 1'b0;
        exp_wr = 0;
        exp_rd = 0;
        @(negedge aclk);
        axi_read(64'h0, 3, -1, 0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
